// File: rtl/uart_pkg.sv
// ============================================================
// uart_pkg: shared UART states and constants
// Rev 1.0
// ============================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_ACK_START = 3'd4,
        ST_ACK_DATA  = 3'd5,
        ST_ACK_STOP  = 3'd6
    } uart_state_e;

    // Also used by the transmitter when it checks the returned ack frame.
    localparam logic [7:0] c_ack_byte      = 8'hCC;
    localparam int         c_clks_per_bit  = 2604;

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================
// uart_bit_timer: loadable down-counter, strobe when it reaches zero
// Rev 1.0
// ============================================================
`default_nettype none

module uart_bit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             sample_o
);

    logic [WIDTH-1:0] count_q;

    // Loading N gives a strobe N+1 cycles after the load edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign sample_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/uart_rx_ack.sv
// ============================================================
// uart_rx_ack: 8N1 receiver, one-entry holding register, ack frame reply
// Rev 1.0
// ============================================================
`default_nettype none

module uart_rx_ack
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = c_clks_per_bit,
    parameter logic [7:0] ACK_BYTE     = c_ack_byte
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic       ack_out,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int             TW     = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  c_half = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]  c_full = TW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_meta_q, rx_s_q;
    logic [7:0]    data_q;
    logic          valid_q, ack_q, fe_q, ov_q, busy_q;
    logic          ack_d, fe_d, ov_d, load_en, stop_hit;
    logic          tmr_load, sample;
    logic [TW-1:0] tmr_val;
    logic          holding_free;

    assign holding_free = !valid_q || data_ready;

    uart_bit_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .sample_o   (sample)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tmr_load = 1'b0;
        tmr_val  = c_full;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d  = ST_START;
                    tmr_load = 1'b1;
                    tmr_val  = c_half;
                end
            end
            ST_START: begin
                if (sample) begin
                    if (!rx_s_q) begin
                        state_d  = ST_DATA;
                        idx_d    = 3'd0;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    shift_d  = {rx_s_q, shift_q[7:1]};
                    tmr_load = 1'b1;
                    if (idx_q == 3'd7) state_d = ST_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (sample) begin
                    if (rx_s_q && holding_free) begin
                        state_d  = ST_ACK_START;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ACK_START: begin
                if (sample) begin
                    state_d  = ST_ACK_DATA;
                    idx_d    = 3'd0;
                    tmr_load = 1'b1;
                end
            end
            ST_ACK_DATA: begin
                if (sample) begin
                    tmr_load = 1'b1;
                    if (idx_q == 3'd7) state_d = ST_ACK_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            ST_ACK_STOP: begin
                if (sample) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ack line is decoded from the next state so it is registered yet
    // falls on the same cycle the holding register fills.
    always_comb begin
        stop_hit = (state_q == ST_STOP) && sample;
        load_en  = stop_hit && rx_s_q && holding_free;
        fe_d     = stop_hit && !rx_s_q;
        ov_d     = stop_hit && rx_s_q && !holding_free;
        case (state_d)
            ST_ACK_START: ack_d = 1'b0;
            ST_ACK_DATA:  ack_d = ACK_BYTE[idx_d];
            default:      ack_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ack_q   <= 1'b1;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q  <= ack_d;
            fe_q   <= fe_d;
            ov_q   <= ov_d;
            busy_q <= (state_d != ST_IDLE);
            if (load_en) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && data_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign ack_out    = ack_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = fe_q;
    assign overrun    = ov_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: doc/uart_rx_ack.md
# uart_rx_ack

Receiving end of the external UART link: deserialises 8N1 frames from the serial line, hands each good byte to the local bus side through a one-entry valid/ready holding register, and answers each accepted frame with an acknowledge frame (0xCC) on a separate ack line. It is the direct peer of the UART transmitter: it produces the data bytes that transmitter sends and the ack frame that transmitter checks before ending or retrying. Frames it cannot accept (framing error, holding register full) are not acknowledged, so the sender's timeout/retransmit logic recovers them.

## Interface
- CLKS_PER_BIT, 2604, clk cycles per bit time (50 MHz / 19200 baud); must be ≥ 8.
- ACK_BYTE, 8'hCC, byte returned on ack_out for every accepted frame.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- rx_in  input  1  serial data from the transmitter, idle high, asynchronous to clk.
- ack_out  output  1  serial ack line to the transmitter, idle high; reset 1.
- data_out  output  8  received byte, stable while data_valid=1; reset 0.
- data_valid  output  1  holding register full; reset 0.
- data_ready  input  1  consumer accepts byte when data_valid & data_ready at a clk edge.
- frame_err  output  1  one-cycle pulse, stop bit sampled low; reset 0.
- overrun  output  1  one-cycle pulse, good frame dropped because holding register full; reset 0.
- busy  output  1  high in every state except IDLE; reset 0.

## Operation
- rx_in passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised value rx_s.
- States: IDLE, START, DATA, STOP, ACK_START, ACK_DATA, ACK_STOP.
- IDLE: on rx_s=0 clear bit timer, go START.
- START: after CLKS_PER_BIT/2 cycles sample rx_s; 0 → DATA, bit index 0; 1 → glitch, back to IDLE, no flags.
- DATA: every CLKS_PER_BIT cycles sample rx_s into shift register, LSB first; after 8th sample → STOP.
- STOP: after CLKS_PER_BIT cycles sample rx_s.
  - 0 → frame_err pulse, no load, no ack, → IDLE.
  - 1, holding empty (or being drained the same cycle) → load data_out, set data_valid, → ACK_START.
  - 1, holding full and not drained → overrun pulse, byte dropped, no ack, → IDLE.
- ACK_START: ack_out=0 for CLKS_PER_BIT cycles → ACK_DATA.
- ACK_DATA: ack_out = ACK_BYTE[i], i=0..7, each CLKS_PER_BIT cycles → ACK_STOP.
- ACK_STOP: ack_out=1 for CLKS_PER_BIT cycles → IDLE.
- rx_s ignored during ACK_* states; a frame starting then is lost (sender retries).
- data_valid clears on the edge where data_valid & data_ready; independent of FSM state.
- Simultaneous load and drain in the same cycle: new byte loaded, data_valid stays 1, no overrun.
- Reset at any point: FSM → IDLE, ack_out=1 next cycle, holding register cleared, in-flight frame discarded.

## Timing
- Let T0 = first cycle rx_s=0 in IDLE. Start sample at T0+CLKS_PER_BIT/2; data bit i at T0+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT; stop at T0+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
- data_valid, frame_err, overrun assert on the cycle after the stop sample (registered).
- ack_out falls the same cycle data_valid rises; ack frame occupies exactly 10·CLKS_PER_BIT cycles, then busy falls.
- Input latency rx_in→rx_s: 2 cycles.
- Bit timer width: $clog2(CLKS_PER_BIT); bit index 3 bits, wraps only via explicit reset on state entry.

## Structure
- Package uart_pkg: state enum, ACK_BYTE default 8'hCC (shared with the transmitter's ack compare), default CLKS_PER_BIT.
- Sub-module uart_bit_timer: loadable down-counter giving a one-cycle "sample" strobe at half-bit or full-bit intervals; reused by RX and ACK phases.

## Test plan
- CLKS_PER_BIT=16, send 0xA5 with data_ready=1 → data_out=0xA5, data_valid for 1 cycle, ack_out waveform 0,0,0,1,1,0,0,1,1,1 (start, 0xCC LSB first, stop), busy low after 10 bits.
- Send 0x3C with stop bit driven 0 → frame_err one pulse, data_valid stays 0, ack_out stays 1.
- data_ready=0, send 0x11 then 0x22 → data_out holds 0x11, overrun pulse on second frame, only first frame acked.
- 4-cycle low glitch on rx_in in IDLE → no flags, returns IDLE, ack_out=1.
- Assert reset mid DATA and mid ACK_DATA → ack_out=1 and busy=0 the cycle after reset; next frame 0x5A received correctly.
- data_ready asserted exactly on stop-sample cycle with a held byte → new byte loaded, no overrun, ack sent.
